// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator.
// Accepts one 512-bit block as sixteen 32-bit words (W0 first), then streams
// the schedule words W[0..ROUNDS-1] one per cycle under valid/ready control.
// W[0..15] are the loaded words. Later words are expanded in place inside a
// 16-entry circular buffer.
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-low reset
//   load_valid - message word offered
//   load_ready - block can accept a message word (IDLE/LOAD)
//   load_data  - message word
//   w_valid    - schedule word presented
//   w_ready    - downstream accepts the schedule word
//   w_data     - schedule word W[t]
//   w_index    - t
//   w_last     - W[ROUNDS-1] is presented
//   busy       - block in LOAD or EMIT
module sha256_msg_sched #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_index,
  output logic        w_last,
  output logic        busy
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  load_cnt_r;
  logic [31:0] buf_r [16];
  logic        load_xfer_s;
  logic        w_xfer_s;
  logic [5:0]  next_idx_s;
  logic [3:0]  next_slot_s;
  logic [3:0]  t_lo_s;
  logic [31:0] w_next_s;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  // load_ready is high exactly when not in EMIT and w_valid exactly when in
  // EMIT, so the two transfer strobes are mutually exclusive.
  assign load_xfer_s = load_valid & load_ready;
  assign w_xfer_s    = w_valid & w_ready;

  assign next_idx_s  = w_index + 6'd1;
  assign next_slot_s = next_idx_s[3:0];
  assign t_lo_s      = w_index[3:0];

  // Schedule word following the one currently presented. While W[t] is on the
  // output, W[t] and all older words still needed are in the buffer; the slot
  // of W[t+1] still holds W[t-15], which is the W[t+1-16] term.
  always_comb begin
    w_next_s = 32'h0000_0000;
    if (next_idx_s < 6'd16) begin
      w_next_s = buf_r[next_slot_s];
    end else begin
      w_next_s = sigma1(buf_r[t_lo_s - 4'd1]) + buf_r[t_lo_s - 4'd6]
               + sigma0(buf_r[t_lo_s - 4'd14]) + buf_r[next_slot_s];
    end
  end

  // Next-state logic for the IDLE/LOAD/EMIT sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_xfer_s) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        if (load_xfer_s && (load_cnt_r == 4'd15)) begin
          state_next_s = EMIT;
        end else begin
          state_next_s = LOAD;
        end
      end
      EMIT: begin
        if (w_xfer_s && w_last) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = EMIT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Load counter and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_cnt_r <= 4'd0;
      load_ready <= 1'b1;
      w_valid    <= 1'b0;
      w_data     <= 32'h0000_0000;
      w_index    <= 6'd0;
      w_last     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      load_ready <= (state_next_s != EMIT);
      busy       <= (state_next_s != IDLE);
      if (load_xfer_s) begin
        if (load_cnt_r == 4'd15) begin
          // Slot 0 was written 15 transfers ago, so W0 can be presented now.
          load_cnt_r <= 4'd0;
          w_valid    <= 1'b1;
          w_data     <= buf_r[0];
          w_index    <= 6'd0;
          w_last     <= 1'b0;
        end else begin
          load_cnt_r <= load_cnt_r + 4'd1;
        end
      end else if (w_xfer_s) begin
        if (w_last) begin
          w_valid <= 1'b0;
          w_data  <= 32'h0000_0000;
          w_index <= 6'd0;
          w_last  <= 1'b0;
        end else begin
          w_data  <= w_next_s;
          w_index <= next_idx_s;
          w_last  <= (next_idx_s == LAST_IDX);
        end
      end else begin
        load_cnt_r <= load_cnt_r;
      end
    end
  end

  // Circular message buffer: loaded words, then expanded words in slot t mod 16.
  // Contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && load_xfer_s) begin
      buf_r[load_cnt_r] <= load_data;
    end else if (rst && w_xfer_s && !w_last && (next_idx_s >= 6'd16)) begin
      buf_r[next_slot_s] <= w_next_s;
    end else begin
      buf_r[0] <= buf_r[0];
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed self-checking bench for sha256_msg_sched (ROUNDS = 64).
module tb_sha256_msg_sched;
  localparam int ROUNDS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'h0;
  logic        w_ready = 1'b0;
  logic        load_ready;
  logic        w_valid;
  logic [31:0] w_data;
  logic [5:0]  w_index;
  logic        w_last;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] blk [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_data [64];
  logic [5:0]  got_idx [64];
  logic        got_last [64];
  int          got_n;
  int          got_cycles;
  int          last_bad;

  sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_index(w_index), .w_last(w_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic build_expected();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk[t];
      else exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  task automatic set_abc();
    for (int k = 0; k < 16; k++) blk[k] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_expected();
  endtask

  task automatic load_block();
    for (int k = 0; k < 16; k++) begin
      load_valid = 1'b1;
      load_data  = blk[k];
      tick();
    end
    load_valid = 1'b0;
    load_data  = 32'h0;
  endtask

  // Drains one block with w_ready held high, recording each accepted word.
  task automatic collect_stream(input bit rand_load);
    got_n = 0; got_cycles = 0; last_bad = 0;
    w_ready = 1'b1;
    while (got_n < ROUNDS && got_cycles < 300) begin
      if (w_last && !w_valid) last_bad++;
      if (w_valid) begin
        got_data[got_n] = w_data;
        got_idx[got_n]  = w_index;
        got_last[got_n] = w_last;
        got_n++;
      end
      if (rand_load && got_n < ROUNDS) begin
        load_valid = 1'b1;
        load_data  = $urandom;
      end else begin
        load_valid = 1'b0;
      end
      tick();
      got_cycles++;
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_checks++;
    if (w_valid !== 1'b0 || w_data !== 32'h0 || w_index !== 6'd0 || w_last !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h i=%0d l=%b b=%b expected all zero", w_valid, w_data, w_index, w_last, busy);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b busy=%b valid=%b expected 1 0 0", load_ready, busy, w_valid);
    end
  endtask

  task automatic test_abc();
    int bad = 0;
    set_abc();
    load_block();
    n_checks++;
    if (w_valid !== 1'b1 || w_data !== 32'h61626380 || w_index !== 6'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abc_first: got v=%b d=%h i=%0d busy=%b expected 1 61626380 0 1", w_valid, w_data, w_index, busy);
    end
    collect_stream(1'b0);
    n_checks++;
    if (got_n !== 64 || got_cycles !== 64) begin
      n_fail++;
      $display("FAIL abc_count: got %0d words in %0d cycles expected 64 in 64", got_n, got_cycles);
    end
    for (int t = 0; t < 64; t++) begin
      n_checks++;
      if (got_data[t] !== exp_w[t] || got_idx[t] !== 6'(t) || got_last[t] !== (t == 63)) begin
        n_fail++;
        $display("FAIL abc_w[%0d]: got %h idx %0d last %b expected %h idx %0d last %b",
                 t, got_data[t], got_idx[t], got_last[t], exp_w[t], t, (t == 63));
      end
    end
    n_checks++;
    if (got_data[16] !== 32'h61626380 || got_data[17] !== 32'h000F0000 || got_data[63] !== 32'h12B1EDEB) begin
      n_fail++;
      $display("FAIL abc_known: got W16=%h W17=%h W63=%h expected 61626380 000f0000 12b1edeb",
               got_data[16], got_data[17], got_data[63]);
    end
    n_checks++;
    if (w_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0 || last_bad !== 0) begin
      n_fail++;
      $display("FAIL abc_end: got v=%b ready=%b busy=%b lastbad=%0d expected 0 1 0 0", w_valid, load_ready, busy, last_bad);
    end
    bad = bad;
  endtask

  task automatic test_zero();
    for (int k = 0; k < 16; k++) blk[k] = 32'h0;
    build_expected();
    load_block();
    collect_stream(1'b0);
    n_checks++;
    if (got_n !== 64) begin
      n_fail++;
      $display("FAIL zero_count: got %0d expected 64", got_n);
    end
    for (int t = 0; t < 64; t++) begin
      n_checks++;
      if (got_data[t] !== 32'h0 || got_idx[t] !== 6'(t)) begin
        n_fail++;
        $display("FAIL zero_w[%0d]: got %h idx %0d expected 00000000 idx %0d", t, got_data[t], got_idx[t], t);
      end
    end
    n_checks++;
    if (load_ready !== 1'b1 || w_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_end: got ready=%b valid=%b expected 1 0", load_ready, w_valid);
    end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    set_abc();
    load_block();
    w_ready = 1'b1;
    while (!(w_valid && w_index == 6'd17) && guard < 100) begin
      tick();
      guard++;
    end
    w_ready = 1'b0;
    n_checks++;
    if (guard !== 17) begin
      n_fail++;
      $display("FAIL bp_reach17: got %0d cycles expected 17", guard);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (w_valid !== 1'b1 || w_data !== 32'h000F0000 || w_index !== 6'd17 || w_last !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h i=%0d expected 1 000f0000 17", c, w_valid, w_data, w_index);
      end
    end
    w_ready = 1'b1;
    tick();
    n_checks++;
    if (w_valid !== 1'b1 || w_data !== exp_w[18] || w_index !== 6'd18) begin
      n_fail++;
      $display("FAIL bp_resume: got v=%b d=%h i=%0d expected 1 %h 18", w_valid, w_data, w_index, exp_w[18]);
    end
    guard = 0;
    while (w_valid && guard < 100) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard !== 46) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d cycles expected 46", guard);
    end
  endtask

  task automatic test_reset_mid_load();
    set_abc();
    for (int k = 0; k < 5; k++) begin
      load_valid = 1'b1;
      load_data  = 32'hDEAD0000 + 32'(k);
      tick();
    end
    load_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || load_ready !== 1'b1 || w_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstload_state: got busy=%b ready=%b valid=%b expected 0 1 0", busy, load_ready, w_valid);
    end
    load_block();
    collect_stream(1'b0);
    for (int t = 0; t < 64; t++) begin
      n_checks++;
      if (got_data[t] !== exp_w[t] || got_idx[t] !== 6'(t)) begin
        n_fail++;
        $display("FAIL rstload_w[%0d]: got %h expected %h", t, got_data[t], exp_w[t]);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    int guard = 0;
    set_abc();
    load_block();
    w_ready = 1'b1;
    while (!(w_valid && w_index == 6'd30) && guard < 100) begin
      tick();
      guard++;
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++;
    if (w_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0 || w_index !== 6'd0 || w_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstemit_state: got v=%b ready=%b busy=%b i=%0d d=%h expected 0 1 0 0 0",
               w_valid, load_ready, busy, w_index, w_data);
    end
    tick();
    n_checks++;
    if (w_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstemit_discard: got valid=%b expected 0", w_valid);
    end
    load_block();
    collect_stream(1'b0);
    n_checks++;
    if (got_n !== 64 || got_cycles !== 64) begin
      n_fail++;
      $display("FAIL rstemit_count: got %0d in %0d expected 64 in 64", got_n, got_cycles);
    end
    for (int t = 0; t < 64; t++) begin
      n_checks++;
      if (got_data[t] !== exp_w[t] || got_idx[t] !== 6'(t) || got_last[t] !== (t == 63)) begin
        n_fail++;
        $display("FAIL rstemit_w[%0d]: got %h expected %h", t, got_data[t], exp_w[t]);
      end
    end
  endtask

  task automatic test_load_during_emit();
    set_abc();
    load_block();
    collect_stream(1'b1);
    n_checks++;
    if (got_n !== 64 || got_cycles !== 64) begin
      n_fail++;
      $display("FAIL ldemit_count: got %0d in %0d expected 64 in 64", got_n, got_cycles);
    end
    for (int t = 0; t < 64; t++) begin
      n_checks++;
      if (got_data[t] !== exp_w[t] || got_idx[t] !== 6'(t)) begin
        n_fail++;
        $display("FAIL ldemit_w[%0d]: got %h expected %h", t, got_data[t], exp_w[t]);
      end
    end
    tick();
    n_checks++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ldemit_idle: got v=%b busy=%b ready=%b expected 0 0 1", w_valid, busy, load_ready);
    end
  endtask

  task automatic test_load_gaps();
    int k = 0;
    int early = 0;
    set_abc();
    w_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (k < 16) begin
        n_checks++;
        if (load_ready !== 1'b1 || w_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL gaps_loading[%0d]: got ready=%b valid=%b expected 1 0", c, load_ready, w_valid);
        end
        // Force a transfer when the remaining cycles just cover the remaining words.
        if ((40 - c) <= (16 - k) + 4 || $urandom_range(0, 1) == 1) begin
          load_valid = 1'b1;
          load_data  = blk[k];
          k++;
        end else begin
          load_valid = 1'b0;
          load_data  = $urandom;
        end
        tick();
        if (k == 16 && load_valid) begin
          n_checks++;
          if (w_valid !== 1'b1 || w_data !== exp_w[0] || w_index !== 6'd0) begin
            n_fail++;
            $display("FAIL gaps_first: got v=%b d=%h i=%0d expected 1 %h 0", w_valid, w_data, w_index, exp_w[0]);
          end
        end
      end else begin
        load_valid = ($urandom_range(0, 1) == 1);
        load_data  = $urandom;
        tick();
        if (w_valid !== 1'b1 || w_index !== 6'd0) early++;
      end
    end
    load_valid = 1'b0;
    n_checks++;
    if (k !== 16 || early !== 0) begin
      n_fail++;
      $display("FAIL gaps_captured: got %0d words sent, %0d unstable cycles expected 16 and 0", k, early);
    end
    collect_stream(1'b0);
    for (int t = 0; t < 64; t++) begin
      n_checks++;
      if (got_data[t] !== exp_w[t] || got_idx[t] !== 6'(t)) begin
        n_fail++;
        $display("FAIL gaps_w[%0d]: got %h expected %h", t, got_data[t], exp_w[t]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_zero();
    test_backpressure();
    test_reset_mid_load();
    test_reset_mid_emit();
    test_load_during_emit();
    test_load_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
